// File: rtl/csa_resolve_80.sv
// Carry-save to binary resolver: captures a sum/carry pair and adds it
// CHUNK bits per cycle, then holds the WIDTH-bit result under valid/ready.
module csa_resolve_80 #(
  parameter int WIDTH = 80,
  parameter int CHUNK = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             cout_r, cy;
  logic [CNTW-1:0]  cnt;
  logic             idle_ready;
  logic             accept;
  logic [CHUNK-1:0] a_sl [NCHUNK];
  logic [CHUNK-1:0] b_sl [NCHUNK];
  logic [CHUNK:0]   slice_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_sl[gi] = op_a[gi*CHUNK +: CHUNK];
      assign b_sl[gi] = op_b[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign slice_sum = {1'b0, a_sl[cnt]} + {1'b0, b_sl[cnt]} + (CHUNK+1)'(cy);

  // in_ready is held low while reset is asserted, independent of state.
  assign in_ready = idle_ready & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    idle_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        idle_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cout_r <= 1'b0;
      cy     <= 1'b0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        op_a <= in_sum;
        op_b <= in_carry;
        cy   <= 1'b0;
        cnt  <= '0;
      end
      if (state == ADD) begin
        res[int'(cnt)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
        cy  <= slice_sum[CHUNK];
        cnt <= cnt + 1'b1;
        if (cnt == LAST) cout_r <= slice_sum[CHUNK];
      end
    end
  end

  assign out_data = res;
  assign out_cout = cout_r;

endmodule

// File: tb/tb_csa_resolve_80.sv
// Self-checking bench for csa_resolve_80: directed vector table, random
// operands against an arithmetic model, and handshake/reset sequences.
module tb_csa_resolve_80;
  localparam int W  = 80;
  localparam int NC = 4;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, out_cout;
  logic [W-1:0] in_sum, in_carry, out_data;

  int  tests = 0;
  int  fails = 0;
  time acc_t;

  csa_resolve_80 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cout(out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         c;
    string        nm;
  } vec_t;

  vec_t vt[7];

  function automatic logic [W-1:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic check(input string nm, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offers one operand pair and returns just after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    in_sum   = a;
    in_carry = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {80'b0, in_ready}, 81'd1);
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
    in_sum   = rnd80();
    in_carry = rnd80();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    logic [W:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b};
    out_ready = 1'b1;
    start_op(a, b);
    wait_valid(lat);
    check({nm, "_latency"}, lat, NC);
    check({nm, "_data"}, {1'b0, out_data}, {1'b0, exp[W-1:0]});
    check({nm, "_cout"}, {80'b0, out_cout}, {80'b0, exp[W]});
    $display("[TB] %s a=%h b=%h -> data=%h cout=%0d lat=%0d", nm, a, b, out_data, out_cout, lat);
    @(posedge clk);
    #1;
    check({nm, "_valid_drop"}, {80'b0, out_valid}, 81'd0);
    check({nm, "_ready_back"}, {80'b0, in_ready}, 81'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   exp;
    int           lat;
    time          t_acc[3];

    vt[0] = '{80'hFFFFF_FFFFF_FFFFF_FFFFF, 80'h1, 80'h0, 1'b1, "full_ripple"};
    vt[1] = '{80'h000FFFFF, 80'h1, 80'h00100000, 1'b0, "bnd20"};
    vt[2] = '{80'hFF_FFFF_FFFF, 80'h1, 80'h100_0000_0000, 1'b0, "bnd40"};
    vt[3] = '{80'hFFF_FFFF_FFFF_FFFF, 80'h1, 80'h1000_0000_0000_0000, 1'b0, "bnd60"};
    vt[4] = '{80'hFFFFFFFFFE0000000001 - 80'h0F0F0F0F0F0F0F0F0F0F,
              80'h0F0F0F0F0F0F0F0F0F0F, 80'hFFFFFFFFFE0000000001, 1'b0, "product"};
    vt[5] = '{80'h8000_0000_0000_0000_0000, 80'h8000_0000_0000_0000_0000, 80'h0, 1'b1, "top_cout"};
    vt[6] = '{80'h0, 80'h0, 80'h0, 1'b0, "zero"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
    #7;
    check("por_valid", {80'b0, out_valid}, 81'd0);
    check("por_data", {1'b0, out_data}, 81'd0);
    check("por_ready", {80'b0, in_ready}, 81'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("por_ready_release", {80'b0, in_ready}, 81'd1);

    // Mid-cycle reset while a result is being held.
    out_ready = 1'b0;
    start_op(80'h12345, 80'h54321);
    wait_valid(lat);
    check("pre_rst_valid", {80'b0, out_valid}, 81'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", {80'b0, out_valid}, 81'd0);
    check("rst_data", {1'b0, out_data}, 81'd0);
    check("rst_cout", {80'b0, out_cout}, 81'd0);
    check("rst_ready", {80'b0, in_ready}, 81'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_hold", {80'b0, in_ready}, 81'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready_release", {80'b0, in_ready}, 81'd1);

    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b1;
      start_op(vt[i].a, vt[i].b);
      wait_valid(lat);
      check({vt[i].nm, "_latency"}, lat, NC);
      check({vt[i].nm, "_data"}, {1'b0, out_data}, {1'b0, vt[i].d});
      check({vt[i].nm, "_cout"}, {80'b0, out_cout}, {80'b0, vt[i].c});
      $display("[TB] %s -> data=%h cout=%0d", vt[i].nm, out_data, out_cout);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 20; i++) begin
      ra = rnd80();
      rb = rnd80();
      do_op(ra, rb, "rand");
    end

    // Backpressure with new operands offered while the result is held.
    ra = rnd80();
    rb = rnd80();
    exp = {1'b0, ra} + {1'b0, rb};
    out_ready = 1'b0;
    start_op(ra, rb);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_sum   = rnd80();
      in_carry = rnd80();
      #1;
      check("bp_valid", {80'b0, out_valid}, 81'd1);
      check("bp_data", {1'b0, out_data}, {1'b0, exp[W-1:0]});
      check("bp_cout", {80'b0, out_cout}, {80'b0, exp[W]});
      check("bp_ready", {80'b0, in_ready}, 81'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {80'b0, out_valid}, 81'd0);
    check("bp_release_ready", {80'b0, in_ready}, 81'd1);
    $display("[TB] backpressure result=%h released", exp[W-1:0]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_no_capture", {80'b0, out_valid}, 81'd0);
    end

    // Reset after two slices, then three back-to-back operations.
    start_op(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_valid", {80'b0, out_valid}, 81'd0);
    check("abort_data", {1'b0, out_data}, 81'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", {80'b0, out_valid}, 81'd0);
    end
    for (int i = 0; i < 3; i++) begin
      ra = rnd80();
      rb = rnd80();
      do_op(ra, rb, "b2b");
      t_acc[i] = acc_t;
    end
    check("b2b_gap1", 81'(int'((t_acc[1] - t_acc[0]) / 10)), 81'd6);
    check("b2b_gap2", 81'(int'((t_acc[2] - t_acc[1]) / 10)), 81'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csa_resolve_80.md
# csa_resolve_80

Multi-cycle carry-propagate stage that turns the redundant carry-save pair from the 40x40 multiplier's CSA reduction tree into one binary 80-bit product. It sits directly downstream of the tree. It captures the sum/carry vectors under a valid/ready handshake and resolves them in CHUNK-bit slices, one slice per cycle, so no full 80-bit ripple adder lands on the critical path. It then presents the result under a second valid/ready handshake.

## Interface
- WIDTH, 80: operand and result width; must be a multiple of CHUNK.
- CHUNK, 20: bits resolved per cycle; NCHUNK = WIDTH/CHUNK (default 4).

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers an operand pair.
- in_ready  out  1  block can accept an operand pair.
- in_sum  in  WIDTH  carry-save vector 0 (tree output B_0).
- in_carry  in  WIDTH  carry-save vector 1 (tree output B_1).
- out_valid  out  1  out_data/out_cout hold a resolved result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_cout  out  1  bit WIDTH of in_sum + in_carry; always 0 for a legal 40x40 product.

## Operation
- Registers:
  - op_a and op_b: WIDTH each.
  - res: WIDTH, drives out_data.
  - cout_r: drives out_cout.
  - cy: 1-bit slice carry.
  - cnt: ceil(log2 NCHUNK) bits.
  - state: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: op_a <= in_sum, op_b <= in_carry, cy <= 0, cnt <= 0; go to ADD.
  - Inputs are sampled only at this edge and may change afterwards.
- ADD:
  - in_ready = 0, out_valid = 0.
  - Each cycle computes {c, s} = op_a[cnt*CHUNK +: CHUNK] + op_b[cnt*CHUNK +: CHUNK] + cy, a (CHUNK+1)-bit result.
  - Then res[cnt*CHUNK +: CHUNK] <= s, cy <= c, cnt <= cnt+1.
  - When cnt == NCHUNK-1: cout_r <= c and go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - res and cout_r hold stable until out_valid & out_ready; on that edge go to IDLE.
- In IDLE and ADD, in_valid is ignored unless in_ready = 1. No input queueing.
- Reset, whether at power-up or asserted mid-ADD or mid-DONE:
  - state = IDLE; res, cout_r, cy and cnt = 0.
  - out_valid = 0, out_data = 0, out_cout = 0.
  - in_ready is forced to 0 while rst is high and returns to 1 in the first cycle after deassertion.
  - Any in-flight operation is discarded and no partial result is ever flagged valid.
- out_data changes only during ADD or at reset. Its value is meaningful only while out_valid = 1.

## Timing
- Accept edge E0 (in_valid & in_ready high).
- Slice k is written at edge E0+k+1, for k = 0..NCHUNK-1.
- out_valid rises after edge E0+NCHUNK: 4 cycles of latency at the defaults.
- If out_ready = 1 when out_valid rises, the output handshake completes at E0+NCHUNK+1 and in_ready returns high in the next cycle.
- The next accept is possible at E0+NCHUNK+2, giving a throughput of 1 operation per NCHUNK+2 cycles (6 at the defaults).
- Backpressure: out_valid stays high and out_data/out_cout stay unchanged for any number of cycles while out_ready = 0.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

## Test plan
1. Reset → outputs cleared:
   - Stimulus: assert rst for 3 cycles, starting mid-cycle.
   - Response: out_valid = 0, out_data = 0, out_cout = 0 immediately, without waiting for a clock edge; in_ready = 0 during reset and 1 in the first cycle after release.
2. Full ripple and carry-out:
   - Stimulus: in_sum = 0xFFFFF_FFFFF_FFFFF_FFFFF, in_carry = 0x1.
   - Response: out_data = 0, out_cout = 1, out_valid high exactly 4 cycles after the accept edge.
3. Slice-boundary carry:
   - Stimulus: in_sum = 0x000FFFFF, in_carry = 0x1.
   - Response: out_data = 0x00100000, out_cout = 0. Repeat at the 40/41-bit and 60/61-bit boundaries.
4. Real product:
   - Stimulus: the carry-save pair for 0xFFFFFFFFFF × 0xFFFFFFFFFF.
   - Response: out_data = 0xFFFFFFFFFE0000000001, out_cout = 0.
5. Backpressure:
   - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises, while pulsing in_valid with new operands.
   - Response: out_data stable, in_ready = 0, new operands not captured. After releasing out_ready, exactly one output handshake occurs, then in_ready = 1.
6. Reset mid-ADD, then back-to-back:
   - Stimulus: assert rst after 2 slices have been written, then stream 3 operand pairs with out_ready = 1.
   - Response: no out_valid from the aborted operation. The 3 pairs are accepted every 6 cycles and their results appear in order, each correct.
